// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset pc default and the NOP encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [2:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_DONE,
        FETCH_FAULT
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one word read per enable, captures the returned word
// and raises ready for a single cycle; a misaligned pc parks the block in FAULT.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        ready,
    input  logic        pc_write_enable,
    input  logic [31:0] pc_write_data,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        mem_read_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_read_data,
    input  logic        mem_read_data_valid,
    output logic        misaligned_fault
);

    fetch_state_e state;

    // Outputs are registered alongside the state so each one is a clean flop
    // that is high exactly while the FSM sits in the matching state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= FETCH_IDLE;
            pc               <= RESET_PC;
            instruction      <= NOP_INSN;
            mem_addr         <= '0;
            ready            <= 1'b0;
            mem_read_req     <= 1'b0;
            misaligned_fault <= 1'b0;
        end else begin
            // The fetch below samples the old pc, so a coincident write only affects later fetches.
            if (pc_write_enable)
                pc <= pc_write_data;

            case (state)
                FETCH_IDLE: begin
                    if (enable) begin
                        if (!is_word_aligned(pc)) begin
                            state            <= FETCH_FAULT;
                            misaligned_fault <= 1'b1;
                        end else begin
                            state        <= FETCH_REQ;
                            mem_addr     <= pc[31:2];
                            mem_read_req <= 1'b1;
                        end
                    end
                end
                FETCH_REQ: begin
                    if (mem_ready) begin
                        state        <= FETCH_WAIT;
                        mem_read_req <= 1'b0;
                    end
                end
                FETCH_WAIT: begin
                    if (mem_read_data_valid) begin
                        state       <= FETCH_DONE;
                        instruction <= mem_read_data;
                        ready       <= 1'b1;
                    end
                end
                FETCH_DONE: begin
                    state <= FETCH_IDLE;
                    ready <= 1'b0;
                end
                FETCH_FAULT: begin
                    // Only reset leaves this state.
                    misaligned_fault <= 1'b1;
                end
                default: begin
                    state            <= FETCH_IDLE;
                    ready            <= 1'b0;
                    mem_read_req     <= 1'b0;
                    misaligned_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized fetches
// against a latency/memory reference model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        ready;
    logic        pc_write_enable;
    logic [31:0] pc_write_data;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        mem_read_req;
    logic [29:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_read_data;
    logic        mem_read_data_valid;
    logic        misaligned_fault;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .enable             (enable),
        .ready              (ready),
        .pc_write_enable    (pc_write_enable),
        .pc_write_data      (pc_write_data),
        .pc                 (pc),
        .instruction        (instruction),
        .mem_read_req       (mem_read_req),
        .mem_addr           (mem_addr),
        .mem_ready          (mem_ready),
        .mem_read_data      (mem_read_data),
        .mem_read_data_valid(mem_read_data_valid),
        .misaligned_fault   (misaligned_fault)
    );

    // Instruction memory contents; word 0 holds 0xDEADBEEF.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [31:0] b;
        b = {a, 2'b00};
        return (b * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0; enable = 1'b0; pc_write_enable = 1'b0; pc_write_data = '0;
        mem_ready = 1'b0; mem_read_data_valid = 1'b0; mem_read_data = '0;
        step(); step();
        reset_n = 1'b1;
        model_pc = 32'h0;
    endtask

    task automatic write_pc(input logic [31:0] v);
        pc_write_enable = 1'b1; pc_write_data = v;
        step();
        pc_write_enable = 1'b0;
        model_pc = v;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_insn"}, instruction, 32'h0000_0013);
        chk({tag, "_addr"}, {2'b00, mem_addr}, 32'h0);
        chk({tag, "_ready"}, {31'b0, ready}, 32'h0);
        chk({tag, "_req"}, {31'b0, mem_read_req}, 32'h0);
        chk({tag, "_fault"}, {31'b0, misaligned_fault}, 32'h0);
    endtask

    // One fetch: memory accepts after acc_d extra request cycles and returns data
    // dat_d cycles after the accept. Expected ready cycle is N + acc_d + dat_d + 2.
    task automatic fetch(input int acc_d, input int dat_d, input logic wr, input logic [31:0] wr_data);
        logic [29:0] ea;
        logic [31:0] w;
        int reqcnt, wcnt, phase, pulses;
        ea = model_pc[31:2];
        w  = mem_word(ea);
        reqcnt = 0; wcnt = 0; phase = 0; pulses = 0;
        enable = 1'b1; pc_write_enable = wr; pc_write_data = wr_data;
        mem_ready = 1'b0; mem_read_data_valid = 1'($urandom_range(0, 1)); mem_read_data = $urandom;
        @(negedge clk);
        chk("idle_req", {31'b0, mem_read_req}, 32'h0);
        step();
        enable = 1'b0; pc_write_enable = 1'b0;
        if (wr) model_pc = wr_data;
        for (int c = 1; c <= 60 && phase < 3; c++) begin
            case (phase)
                0: begin
                    reqcnt++;
                    mem_ready = (reqcnt > acc_d);
                    mem_read_data_valid = 1'($urandom_range(0, 1));
                    mem_read_data = $urandom;
                end
                1: begin
                    wcnt++;
                    mem_ready = 1'($urandom_range(0, 1));
                    mem_read_data_valid = (wcnt == dat_d);
                    mem_read_data = (wcnt == dat_d) ? w : $urandom;
                end
                default: begin
                    mem_ready = 1'b0;
                    mem_read_data_valid = 1'($urandom_range(0, 1));
                    mem_read_data = $urandom;
                end
            endcase
            @(negedge clk);
            if (ready) pulses++;
            case (phase)
                0: begin
                    chk("req_high", {31'b0, mem_read_req}, 32'h1);
                    chk("req_addr", {2'b00, mem_addr}, {2'b00, ea});
                    chk("req_ready", {31'b0, ready}, 32'h0);
                    if (mem_ready) phase = 1;
                end
                1: begin
                    chk("wait_req", {31'b0, mem_read_req}, 32'h0);
                    chk("wait_ready", {31'b0, ready}, 32'h0);
                    if (mem_read_data_valid) phase = 2;
                end
                default: begin
                    chk("done_ready", {31'b0, ready}, 32'h1);
                    chk("done_latency", c, acc_d + dat_d + 2);
                    chk("done_insn", instruction, w);
                    chk("done_addr", {2'b00, mem_addr}, {2'b00, ea});
                    phase = 3;
                end
            endcase
            step();
        end
        chk("fetch_timeout", phase, 3);
        chk("req_cycles", reqcnt, acc_d + 1);
        // Idle cycle after DONE: stray valid must not disturb the captured word.
        enable = 1'b0; mem_ready = 1'b0;
        mem_read_data_valid = 1'b1; mem_read_data = ~w;
        @(negedge clk);
        if (ready) pulses++;
        chk("post_ready", {31'b0, ready}, 32'h0);
        chk("post_req", {31'b0, mem_read_req}, 32'h0);
        chk("post_insn_hold", instruction, w);
        chk("pc_no_incr", pc, model_pc);
        chk("ready_pulses", pulses, 1);
        step();
        mem_read_data_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_reset_state("rst");
        step();

        // Minimum latency, word 0
        fetch(0, 1, 1'b0, 32'h0);
        chk("beef_insn", instruction, 32'hDEAD_BEEF);

        // Slow memory: 5 stalled request cycles, data 4 cycles after accept
        fetch(5, 4, 1'b0, 32'h0);

        // Misaligned pc -> sticky fault
        write_pc(32'h0000_0102);
        enable = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; mem_read_data_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("fault_set", {31'b0, misaligned_fault}, 32'h1);
            chk("fault_req", {31'b0, mem_read_req}, 32'h0);
            chk("fault_ready", {31'b0, ready}, 32'h0);
            step();
        end
        enable = 1'b0;
        write_pc(32'h0000_0100);
        @(negedge clk);
        chk("fault_pc_write", pc, 32'h0000_0100);
        chk("fault_sticky", {31'b0, misaligned_fault}, 32'h1);
        step();
        do_reset();
        check_reset_state("fault_rst");
        step();

        // pc write coincident with enable: fetch uses old pc, next fetch uses new pc
        write_pc(32'h0000_0100);
        fetch(0, 1, 1'b1, 32'h0000_0200);
        chk("coinc_pc", pc, 32'h0000_0200);
        fetch(1, 2, 1'b0, 32'h0);

        // Reset while waiting for data; the late data_valid must be ignored
        do_reset();
        write_pc(32'h0000_0040);
        enable = 1'b1;
        step();
        enable = 1'b0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; reset_n = 1'b0;
        step();
        reset_n = 1'b1; mem_read_data_valid = 1'b1; mem_read_data = 32'hCAFE_F00D;
        step();
        mem_read_data_valid = 1'b0;
        model_pc = 32'h0;
        check_reset_state("late_valid");
        step();
        @(negedge clk);
        chk("late_ready", {31'b0, ready}, 32'h0);
        step();

        // Randomized fetches, some with a coincident pc write
        for (int i = 0; i < 10; i++) begin
            logic [31:0] v, nv;
            logic wr;
            v  = $urandom & 32'hFFFF_FFFC;
            nv = $urandom & 32'hFFFF_FFFC;
            wr = 1'($urandom_range(0, 1));
            write_pc(v);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                mem_read_data_valid = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
                step();
            end
            fetch(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), wr, nv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
